uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single FPGA UART transmit pin between NUM_REQ hardware-thread requesters.
- Each requester presents bytes over a valid/ready handshake. A round-robin arbiter picks one requester, and an internal serializer emits 8N1 frames on uart_tx.
- Grant can be locked for a multi-byte message via req_last, so messages from different threads do not interleave.
- Sits between the core's per-thread UART MMIO ports and the top-level uart_tx pin.

Parameters:
- NUM_REQ, 4, number of requesters (hardware threads), 2..8.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200), must be >= 2.
- LOCK_TIMEOUT, 1024, idle cycles after which a locked grant is forcibly released, must be >= 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  8*NUM_REQ  byte for requester i, bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the last of a message; releases the lock when accepted.
- req_ready  out  NUM_REQ  byte accepted this cycle when valid&ready.
- grant_valid  out  1  a requester currently holds the lock.
- grant_id  out  $clog2(NUM_REQ)  index of the lock holder.
- busy  out  1  serializer is mid-frame.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Reset state, applied asynchronously on reset low:
  - uart_tx=1, req_ready=0, grant_valid=0, grant_id=0, busy=0.
  - Round-robin pointer=0, lock timer=0, serializer in IDLE.
- Serializer states:
  - IDLE: uart_tx=1.
  - START: uart_tx=0.
  - DATA: LSB first, 8 bits.
  - STOP: uart_tx=1.
  - Each state lasts exactly CLKS_PER_BIT cycles. A bit counter 0..7 runs in DATA; a cycle counter 0..CLKS_PER_BIT-1 runs in every non-IDLE state.
- ser_ready is high in IDLE and in the final cycle of STOP. This allows gapless back-to-back frames.
- Arbitration happens each cycle ser_ready=1:
  - Unlocked: choose the first i with req_valid[i], searching from the RR pointer upward modulo NUM_REQ.
  - Locked: only grant_id is eligible.
- req_ready is one-hot or zero, combinational from req_valid, lock state and ser_ready. It is never high for more than one requester.
- On transfer (valid&ready of requester i at edge t):
  - Data is latched.
  - START drives uart_tx low from cycle t+1.
  - busy=1 from t+1 until STOP ends. busy stays high across back-to-back frames.
  - RR pointer <= (i+1) mod NUM_REQ.
  - If req_last[i]=0: grant_valid<=1, grant_id<=i.
  - If req_last[i]=1: grant_valid<=0, and grant_id keeps its value.
- Frame length is 10*CLKS_PER_BIT cycles. Earliest next acceptance is edge t+10*CLKS_PER_BIT.
- Lock timeout:
  - While grant_valid=1 and req_valid[grant_id]=0, the timer increments; otherwise it clears.
  - When the timer reaches LOCK_TIMEOUT-1: grant_valid<=0, timer<=0, RR pointer<=(grant_id+1) mod NUM_REQ.
- Simultaneous timeout expiry and a transfer from the holder: the transfer wins and the timer clears. This cannot occur because valid=0 drives the timer, but it must be assertion-checked.
- Requesters must hold req_data and req_last stable while req_valid=1 and req_ready=0. A bench assertion covers this; the RTL does not check it.
- Reset mid-frame aborts immediately: uart_tx returns high and no partial byte is resumed.
- No requester valid: the serializer stays IDLE and outputs are unchanged.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_BITS=8.
  - ser_state_t enum {IDLE, START, DATA, STOP}.
  - Width helper for the requester index.
- Sub-module uart_tx_serializer (clock, reset, in_valid, in_data, in_ready, busy, tx) contains the FSM and bit/cycle counters.
- uart_tx_arbiter contains the round-robin pointer, the lock and its timer, and the one-hot ready generation.

Test Plan (NUM_REQ=4, CLKS_PER_BIT=4, LOCK_TIMEOUT=8):
- Reset mid-frame:
  - Stimulus: assert reset low during DATA.
  - Required: uart_tx=1, busy=0, req_ready=0 immediately.
  - Then: after release, the next byte starts with a full START bit.
- Single byte 0xA5 from req 2 with last=1, accepted at edge t:
  - uart_tx low over cycles t+1..t+4.
  - Bits 1,0,1,0,0,1,0,1 at 4 cycles each.
  - Stop high over t+37..t+40.
  - grant_valid stays 0.
- Round robin: all four valid with last=1, pointer=0:
  - Acceptance order 0,1,2,3,0.
  - Frames spaced exactly 40 cycles with no idle gap.
  - busy continuously 1.
- Lock: req 1 sends 0x11 (last=0) then 0x22 (last=1) while req 0 and req 3 stay valid:
  - Both req 1 bytes go out consecutively.
  - The next grant goes to req 3 (pointer=2, req 2 idle).
- Timeout: req 1 sends last=0 then drops valid, with req 0 valid:
  - Req 0 stays blocked for exactly 8 cycles after req 1 drops valid.
  - grant_valid falls.
  - Req 0 is then accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit arbiter
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  // Index width that stays legal (>= 1 bit) even for a count of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 frame serializer with a handshake byte input
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [UART_DATA_BITS-1:0] in_data,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      tx
);

  localparam int CW = idx_width(CLKS_PER_BIT);
  localparam int BW = idx_width(UART_DATA_BITS);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  ser_state_t                state;
  logic [CW-1:0]             cyc_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      run_q;
  logic                      bit_end;
  logic                      accept;

  assign bit_end = (cyc_cnt == CYC_LAST);
  // Ready in the last STOP cycle lets the next START follow with no idle gap.
  assign in_ready = run_q && ((state == IDLE) || ((state == STOP) && bit_end));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        state   <= START;
        cyc_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= in_data;
        tx      <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cyc_cnt <= '0;
          end
          START: begin
            if (bit_end) begin
              state   <= DATA;
              cyc_cnt <= '0;
              tx      <= shreg[0];
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cyc_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                state <= STOP;
                tx    <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              state   <= IDLE;
              cyc_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-locking share of one UART TX pin
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [UART_DATA_BITS*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                grant_valid,
  output logic [idx_width(NUM_REQ)-1:0]       grant_id,
  output logic                                busy,
  output logic                                uart_tx
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int TW = idx_width(LOCK_TIMEOUT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NUM_REQ_W  = (IW + 1)'(NUM_REQ);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

  logic [IW-1:0]             rr_ptr;
  logic [TW-1:0]             lock_timer;
  logic [NUM_REQ-1:0]        rr_pick;
  logic [IW-1:0]             cand;
  logic [IW:0]               cand_sum;
  logic                      found;
  logic                      ser_ready;
  logic                      xfer;
  logic [IW-1:0]             xfer_id;
  logic                      xfer_last;
  logic [UART_DATA_BITS-1:0] ser_data;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    rr_pick  = '0;
    found    = 1'b0;
    cand     = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (cand_sum >= NUM_REQ_W) cand_sum = cand_sum - NUM_REQ_W;
      cand = cand_sum[IW-1:0];
      if (!found && req_valid[cand]) begin
        rr_pick[cand] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (ser_ready) begin
      if (grant_valid) req_ready[grant_id] = req_valid[grant_id];
      else             req_ready = rr_pick;
    end
  end

  always_comb begin
    xfer_id   = '0;
    xfer_last = 1'b0;
    ser_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        xfer_id   = IW'(i);
        xfer_last = req_last[i];
        ser_data  = req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
      end
    end
  end

  assign xfer = |req_ready;

  // A transfer always takes priority over timer expiry, so the holder never loses a byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      lock_timer  <= '0;
    end else if (xfer) begin
      rr_ptr     <= next_idx(xfer_id);
      lock_timer <= '0;
      if (xfer_last) begin
        grant_valid <= 1'b0;
      end else begin
        grant_valid <= 1'b1;
        grant_id    <= xfer_id;
      end
    end else if (grant_valid && !req_valid[grant_id]) begin
      if (lock_timer == TIMER_LAST) begin
        grant_valid <= 1'b0;
        lock_timer  <= '0;
        rr_ptr      <= next_idx(grant_id);
      end else begin
        lock_timer <= lock_timer + 1'b1;
      end
    end else begin
      lock_timer <= '0;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock   (clock),
    .reset   (reset),
    .in_valid(xfer),
    .in_data (ser_data),
    .in_ready(ser_ready),
    .busy    (busy),
    .tx      (uart_tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int LT    = 8;
  localparam int FRAME = 10 * CPB;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           busy;
  logic           uart_tx;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .CLKS_PER_BIT(CPB),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .busy       (busy),
    .uart_tx    (uart_tx)
  );

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       last;
    int         edge_no;
  } item_t;

  typedef struct {
    logic [7:0] d;
    int         start;
    bit         bad;
  } rx_t;

  item_t pend[$];
  item_t acc_q[$];
  item_t exp_q[$];
  rx_t   rx_q[$];
  bit    busy_at[int];

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_n = edge_n + 1;

  // Line decoder plus protocol assertions, all sampled on the falling edge.
  bit         rx_act = 0;
  int         rx_pos, rx_start, bitn;
  bit         rx_bad;
  logic       rx_ref;
  logic [7:0] rx_byte;
  logic [N-1:0] pv = '0, pr = '0, pl = '0;
  logic [7:0]   pd [N];

  always @(negedge clock) begin
    busy_at[edge_n] = busy;
    if (reset !== 1'b1) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (uart_tx === 1'b0) begin
        rx_act = 1; rx_pos = 1; rx_start = edge_n; rx_bad = 0; rx_ref = 1'b0; rx_byte = '0;
      end
    end else begin
      bitn = rx_pos / CPB;
      if (rx_pos % CPB == 0) rx_ref = uart_tx;
      else if (uart_tx !== rx_ref) rx_bad = 1;
      if (rx_pos % CPB == 0 && bitn >= 1 && bitn <= 8) rx_byte[bitn-1] = uart_tx;
      if (bitn == 9 && uart_tx !== 1'b1) rx_bad = 1;
      if (rx_pos == FRAME - 1) begin
        rx_q.push_back('{d: rx_byte, start: rx_start, bad: rx_bad});
        rx_act = 0;
      end else begin
        rx_pos = rx_pos + 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (reset === 1'b1 && pv[i] && !pr[i] && req_valid[i])
        assert (req_data[8*i +: 8] === pd[i] && req_last[i] === pl[i]) else begin
          failures++;
          $error("FAIL hold_stable req=%0d observed=%0h/%0b expected=%0h/%0b",
                 i, req_data[8*i +: 8], req_last[i], pd[i], pl[i]);
        end
      pv[i] = req_valid[i]; pr[i] = req_ready[i]; pd[i] = req_data[8*i +: 8]; pl[i] = req_last[i];
    end
    if (reset === 1'b1)
      assert (!(grant_valid && int'(dut.lock_timer) == LT - 1 && req_valid[grant_id] && req_ready[grant_id]))
      else begin
        failures++;
        $error("FAIL timeout_vs_transfer observed=1 expected=0");
      end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enq(input int id, input logic [7:0] d, input logic last);
    pend.push_back('{id: id, d: d, last: last, edge_no: 0});
  endtask

  task automatic drive();
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < pend.size(); j++)
        if (pend[j].id == i) begin
          req_valid[i] = 1'b1; req_data[8*i +: 8] = pend[j].d; req_last[i] = pend[j].last;
          break;
        end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    item_t it;
    #1;
    acc = req_valid & req_ready;
    @(posedge clock); #1;
    for (int i = 0; i < N; i++)
      if (acc[i])
        for (int j = 0; j < pend.size(); j++)
          if (pend[j].id == i) begin
            it = pend[j]; it.edge_no = edge_n; acc_q.push_back(it); pend.delete(j);
            break;
          end
    drive();
    @(negedge clock); #1;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int b = 0;
    while (acc_q.size() < n && b < budget) begin step(); b++; end
    check(tag, acc_q.size(), n);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int b = 0;
    while (rx_q.size() < n && b < budget) begin step(); b++; end
    check(tag, rx_q.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b0; pend.delete(); drive();
    repeat (2) @(negedge clock);
    #1; reset = 1'b1; acc_q.delete(); rx_q.delete();
    @(negedge clock); #1;
  endtask

  // Transaction-level arbitration: pointer and lock over per-requester FIFOs.
  task automatic build_model();
    item_t work[$];
    int ptr = 0, lock = -1, pick, guard = 0;
    work = pend; exp_q.delete();
    while (work.size() > 0 && guard < 200) begin
      guard++; pick = -1;
      if (lock >= 0) pick = lock;
      else
        for (int k = 0; k < N && pick < 0; k++)
          for (int j = 0; j < work.size(); j++)
            if (work[j].id == (ptr + k) % N) begin pick = (ptr + k) % N; break; end
      lock = -1;
      for (int j = 0; j < work.size(); j++)
        if (work[j].id == pick) begin
          exp_q.push_back(work[j]);
          if (!work[j].last) lock = pick;
          work.delete(j);
          break;
        end
      ptr = (pick + 1) % N;
    end
  endtask

  task automatic check_stream(input string tag, input int n);
    int holes = 0;
    wait_rx(n, FRAME + 20, {tag, "_rx_count"});
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size() && i < acc_q.size()) begin
        check({tag, "_rx_byte"}, rx_q[i].d, acc_q[i].d);
        check({tag, "_rx_start"}, rx_q[i].start, acc_q[i].edge_no);
        check({tag, "_rx_shape"}, rx_q[i].bad, 0);
        if (i > 0) check({tag, "_gap"}, acc_q[i].edge_no - acc_q[i-1].edge_no, FRAME);
      end
    end
    if (acc_q.size() >= n && n > 0) begin
      for (int e = acc_q[0].edge_no; e < acc_q[n-1].edge_no + FRAME; e++)
        if (!busy_at.exists(e) || busy_at[e] !== 1'b1) holes++;
      check({tag, "_busy_holes"}, holes, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int t, bad, total, nb;
  int rr_ids[5]   = '{0, 1, 2, 3, 0};
  int rr_dat[5]   = '{8'h30, 8'h41, 8'h52, 8'h63, 8'h31};
  int lk_ids[4]   = '{1, 1, 3, 0};
  int lk_dat[4]   = '{8'h11, 8'h22, 8'h3B, 8'h0A};

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    enq(0, 8'h55, 1'b1); drive();
    repeat (3) @(negedge clock); #1;
    check("reset_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 0);
    check("reset_grant_valid", grant_valid, 0);
    check("reset_grant_id", grant_id, 0);

    // Reset in the middle of DATA, then a clean frame afterwards.
    do_reset();
    enq(0, 8'hC3, 1'b1); drive();
    wait_acc(1, 20, "mf_accept");
    t = (acc_q.size() > 0) ? acc_q[0].edge_no : edge_n;
    while (edge_n < t + 12) step();
    check("mf_busy_before", busy, 1);
    enq(2, 8'h99, 1'b1); drive(); #1;
    reset = 1'b0; #1;
    check("mf_tx", uart_tx, 1);
    check("mf_busy", busy, 0);
    check("mf_ready", req_ready, 0);
    check("mf_grant_valid", grant_valid, 0);
    pend.delete(); drive();
    @(negedge clock); #1;
    reset = 1'b1; acc_q.delete(); rx_q.delete();
    @(negedge clock); #1;
    enq(1, 8'h3C, 1'b1); drive();
    wait_acc(1, 20, "mf_post_accept");
    check_stream("mf_post", 1);
    check("mf_post_count", rx_q.size(), 1);

    // Single byte 0xA5 from requester 2.
    do_reset();
    enq(2, 8'hA5, 1'b1); drive();
    wait_acc(1, 20, "a5_accept");
    t = (acc_q.size() > 0) ? acc_q[0].edge_no : edge_n;
    if (acc_q.size() > 0) check("a5_id", acc_q[0].id, 2);
    bad = 0;
    while (edge_n < t + FRAME) begin
      if (busy !== 1'b1 || grant_valid !== 1'b0) bad++;
      step();
    end
    check("a5_busy_grant", bad, 0);
    check("a5_busy_end", busy, 0);
    check("a5_tx_idle", uart_tx, 1);
    wait_rx(1, 10, "a5_rx_count");
    if (rx_q.size() > 0) begin
      check("a5_byte", rx_q[0].d, 8'hA5);
      check("a5_start", rx_q[0].start, t);
      check("a5_shape", rx_q[0].bad, 0);
    end

    // Round robin with every requester valid.
    do_reset();
    enq(0, 8'h30, 1'b1); enq(0, 8'h31, 1'b1); enq(1, 8'h41, 1'b1);
    enq(2, 8'h52, 1'b1); enq(3, 8'h63, 1'b1); drive();
    wait_acc(5, 5 * FRAME + 20, "rr_accepts");
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      check("rr_id", acc_q[i].id, rr_ids[i]);
      check("rr_data", acc_q[i].d, rr_dat[i]);
    end
    check_stream("rr", 5);

    // Locked two-byte message from requester 1.
    do_reset();
    enq(1, 8'h11, 1'b0); enq(1, 8'h22, 1'b1); drive();
    wait_acc(1, 20, "lk_first");
    check("lk_grant_valid", grant_valid, 1);
    check("lk_grant_id", grant_id, 1);
    enq(0, 8'h0A, 1'b1); enq(3, 8'h3B, 1'b1); drive();
    wait_acc(4, 4 * FRAME + 20, "lk_accepts");
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      check("lk_id", acc_q[i].id, lk_ids[i]);
      check("lk_data", acc_q[i].d, lk_dat[i]);
    end
    check_stream("lk", 4);

    // Lock timeout after the holder drops valid.
    do_reset();
    enq(1, 8'h77, 1'b0); drive();
    wait_acc(1, 20, "to_first");
    t = (acc_q.size() > 0) ? acc_q[0].edge_no : edge_n;
    enq(0, 8'h05, 1'b1); drive();
    while (edge_n < t + LT - 1) step();
    check("to_grant_hold", grant_valid, 1);
    check("to_ready0_blocked", req_ready[0], 0);
    step();
    check("to_grant_drop", grant_valid, 0);
    check("to_grant_id_kept", grant_id, 1);
    wait_acc(2, FRAME + 20, "to_second");
    if (acc_q.size() > 1) begin
      check("to_second_id", acc_q[1].id, 0);
      check("to_second_edge", acc_q[1].edge_no, t + FRAME);
    end

    // Randomised message mixes against the transaction-level model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0 || (i == N - 1 && total == 0)) begin
          nb = $urandom_range(1, 4);
          for (int k = 0; k < nb; k++)
            enq(i, 8'($urandom_range(0, 255)), (k == nb - 1) || ($urandom_range(0, 2) == 0));
          total += nb;
        end
      end
      build_model();
      drive();
      wait_acc(total, total * FRAME + 20, "rnd_accepts");
      for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
        check("rnd_item", acc_q[i].id * 256 + int'(acc_q[i].d), exp_q[i].id * 256 + int'(exp_q[i].d));
      check_stream("rnd", total);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
